// File: rtl/add_scheduler_if.sv
// Bundle for add_scheduler: two-requester request/response handshakes plus the
// operand/result wires of the external shared W-bit adder.
interface add_scheduler_if #(
    parameter int unsigned W = 32
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [4*W-1:0] req_a;
    logic [4*W-1:0] req_b;
    logic [1:0]     req_sub;
    logic [1:0]     req_wide;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [2*W-1:0] resp_sum;
    logic           resp_cout;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_wide, resp_ready, add_sum, add_cout,
        output req_ready, resp_valid, resp_sum, resp_cout, add_a, add_b, add_cin
    );

    // Requesters plus adder side.
    modport master (
        output req_valid, req_a, req_b, req_sub, req_wide, resp_ready, add_sum, add_cout,
        input  req_ready, resp_valid, resp_sum, resp_cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/add_scheduler.sv
// Round-robin scheduler that time-shares one external W-bit adder between two
// requesters, doing 2W-bit operations as a low half then a high half.
module add_scheduler #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    add_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StResp
    } state_e;

    state_e         r_state;
    logic           r_prio;
    logic           r_id;
    logic           r_wide;
    logic [W-1:0]   r_a_hi;
    logic [W-1:0]   r_b_hi;
    logic [W-1:0]   r_add_a;
    logic [W-1:0]   r_add_b;
    logic           r_add_cin;
    logic [2*W-1:0] r_sum;
    logic           r_cout;
    logic [1:0]     r_resp_valid;

    logic           w_any_valid;
    logic           w_gnt_id;
    logic [1:0]     w_req_ready;
    logic           w_resp_hs;
    logic [2*W-1:0] w_sel_a;
    logic [2*W-1:0] w_sel_b;
    logic [2*W-1:0] w_sel_b_eff;
    logic           w_sel_sub;
    logic           w_sel_wide;

    always_comb begin
        w_any_valid = |bus.req_valid;
        unique case (bus.req_valid)
            2'b01:   w_gnt_id = 1'b0;
            2'b10:   w_gnt_id = 1'b1;
            2'b11:   w_gnt_id = r_prio;
            default: w_gnt_id = 1'b0;
        endcase

        // rst_n gates ready so nothing is offered while reset is held.
        w_req_ready = 2'b00;
        if (rst_n && (r_state == StIdle) && w_any_valid) begin
            w_req_ready[w_gnt_id] = 1'b1;
        end

        w_sel_a     = w_gnt_id ? bus.req_a[4*W-1:2*W] : bus.req_a[2*W-1:0];
        w_sel_b     = w_gnt_id ? bus.req_b[4*W-1:2*W] : bus.req_b[2*W-1:0];
        w_sel_sub   = bus.req_sub[w_gnt_id];
        w_sel_wide  = bus.req_wide[w_gnt_id];
        // Subtraction is A + ~B + 1; the +1 enters as the low-half carry-in.
        w_sel_b_eff = w_sel_sub ? ~w_sel_b : w_sel_b;

        w_resp_hs   = (r_state == StResp) && bus.resp_ready[r_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_prio       <= 1'b0;
            r_id         <= 1'b0;
            r_wide       <= 1'b0;
            r_a_hi       <= '0;
            r_b_hi       <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_cin    <= 1'b0;
            r_sum        <= '0;
            r_cout       <= 1'b0;
            r_resp_valid <= 2'b00;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_valid) begin
                        r_id      <= w_gnt_id;
                        r_wide    <= w_sel_wide;
                        r_prio    <= ~w_gnt_id;
                        r_a_hi    <= w_sel_a[2*W-1:W];
                        r_b_hi    <= w_sel_b_eff[2*W-1:W];
                        // Adder operands are registered so they are stable throughout LO.
                        r_add_a   <= w_sel_a[W-1:0];
                        r_add_b   <= w_sel_b_eff[W-1:0];
                        r_add_cin <= w_sel_sub;
                        r_state   <= StLo;
                    end
                end

                StLo: begin
                    r_sum[W-1:0] <= bus.add_sum;
                    if (r_wide) begin
                        r_add_a   <= r_a_hi;
                        r_add_b   <= r_b_hi;
                        r_add_cin <= bus.add_cout;
                        r_state   <= StHi;
                    end else begin
                        r_sum[2*W-1:W] <= '0;
                        r_cout         <= bus.add_cout;
                        r_add_a        <= '0;
                        r_add_b        <= '0;
                        r_add_cin      <= 1'b0;
                        r_resp_valid   <= r_id ? 2'b10 : 2'b01;
                        r_state        <= StResp;
                    end
                end

                StHi: begin
                    r_sum[2*W-1:W] <= bus.add_sum;
                    r_cout         <= bus.add_cout;
                    r_add_a        <= '0;
                    r_add_b        <= '0;
                    r_add_cin      <= 1'b0;
                    r_resp_valid   <= r_id ? 2'b10 : 2'b01;
                    r_state        <= StResp;
                end

                StResp: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= 2'b00;
                        r_state      <= StIdle;
                    end
                end

                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_sum   = r_sum;
    assign bus.resp_cout  = r_cout;
    assign bus.add_a      = r_add_a;
    assign bus.add_b      = r_add_b;
    assign bus.add_cin    = r_add_cin;

endmodule

// File: tb/tb_add_scheduler.sv
// Self-checking bench for add_scheduler: directed corner cases, randomized
// operations against an arithmetic model, round-robin, stall and reset cases.
module tb_add_scheduler;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    add_scheduler_if #(.W(W)) bus ();

    add_scheduler #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The external shared adder.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                         + {{W{1'b0}}, bus.add_cin};

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          n;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        wide;
        logic [63:0] s;
        logic        c;
        int          lat;
    } vec_t;

    vec_t vecs[5];

    // Result of the operation as plain modular arithmetic over the width used.
    function automatic logic [2*W:0] ref_op(logic [2*W-1:0] a, logic [2*W-1:0] b,
                                            logic sub, logic wide);
        logic [2*W-1:0] mask;
        logic [2*W-1:0] am;
        logic [2*W-1:0] bm;
        logic [2*W:0]   t;
        logic           c;
        mask = wide ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}};
        am   = a & mask;
        bm   = b & mask;
        if (sub) begin
            t = {1'b0, (am - bm) & mask};
            c = (am >= bm);
        end else begin
            t = {1'b0, am} + {1'b0, bm};
            c = wide ? t[2*W] : t[W];
            t = {1'b0, t[2*W-1:0] & mask};
        end
        return {c, t[2*W-1:0]};
    endfunction

    task automatic clear_inputs();
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_sub    = 2'b00;
        bus.req_wide   = 2'b00;
        bus.resp_ready = 2'b00;
    endtask

    task automatic drive_req(input int n, input logic [2*W-1:0] a, input logic [2*W-1:0] b,
                             input logic sub, input logic wide);
        if (n == 0) begin
            bus.req_a[2*W-1:0] = a;
            bus.req_b[2*W-1:0] = b;
            bus.req_sub[0]     = sub;
            bus.req_wide[0]    = wide;
            bus.req_valid[0]   = 1'b1;
        end else begin
            bus.req_a[4*W-1:2*W] = a;
            bus.req_b[4*W-1:2*W] = b;
            bus.req_sub[1]       = sub;
            bus.req_wide[1]      = wide;
            bus.req_valid[1]     = 1'b1;
        end
    endtask

    // Returns just after the accepting edge, with req_valid dropped.
    task automatic wait_grant(input int n, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[n]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
    endtask

    // lat counts cycles after the accepting edge; -1 on timeout.
    task automatic wait_resp(output int lat, output logic [1:0] rv,
                             output logic [2*W-1:0] sum, output logic cout);
        lat  = -1;
        rv   = 2'b00;
        sum  = '0;
        cout = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (|bus.resp_valid) begin
                lat  = k;
                rv   = bus.resp_valid;
                sum  = bus.resp_sum;
                cout = bus.resp_cout;
                break;
            end
        end
    endtask

    task automatic ack(input int n);
        bus.resp_ready    = 2'b00;
        bus.resp_ready[n] = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 2'b00;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        bus.req_valid = 2'b11;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b00) begin
            n_errors++; $display("FAIL reset req_ready: got %b want 00", bus.req_ready);
        end
        n_checks++;
        if (bus.resp_valid !== 2'b00) begin
            n_errors++; $display("FAIL reset resp_valid: got %b want 00", bus.resp_valid);
        end
        n_checks++;
        if (bus.resp_sum !== '0 || bus.resp_cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset resp: got %h/%b want 0/0", bus.resp_sum, bus.resp_cout);
        end
        n_checks++;
        if (bus.add_a !== '0 || bus.add_b !== '0 || bus.add_cin !== 1'b0) begin
            n_errors++;
            $display("FAIL reset adder: got %h/%h/%b want 0", bus.add_a, bus.add_b, bus.add_cin);
        end
        #2;
        bus.req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic           ok;
        int             lat;
        logic [1:0]     rv;
        logic [2*W-1:0] sum;
        logic           cout;
        vecs[0] = '{0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 2};
        vecs[1] = '{1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1,
                    64'h0000_0001_0000_0000, 1'b0, 3};
        vecs[2] = '{0, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3};
        vecs[3] = '{1, 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 2};
        vecs[4] = '{0, 64'hDEAD_0000_0000_0003, 64'hBEEF_0000_0000_0002, 1'b1, 1'b0,
                    64'h1, 1'b1, 2};
        for (int i = 0; i < 5; i++) begin
            drive_req(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].wide);
            wait_grant(vecs[i].n, ok);
            n_checks++;
            if (!ok) begin
                n_errors++; $display("FAIL directed%0d grant: got none want req%0d", i, vecs[i].n);
            end
            wait_resp(lat, rv, sum, cout);
            n_checks++;
            if (lat != vecs[i].lat) begin
                n_errors++; $display("FAIL directed%0d latency: got %0d want %0d", i, lat, vecs[i].lat);
            end
            n_checks++;
            if (rv !== 2'(1 << vecs[i].n)) begin
                n_errors++; $display("FAIL directed%0d resp_valid: got %b want %b", i, rv, 2'(1 << vecs[i].n));
            end
            n_checks++;
            if (sum !== vecs[i].s || cout !== vecs[i].c) begin
                n_errors++;
                $display("FAIL directed%0d result: got %h/%b want %h/%b", i, sum, cout, vecs[i].s, vecs[i].c);
            end
            ack(vecs[i].n);
        end
    endtask

    task automatic test_random();
        logic           ok;
        int             lat;
        int             n;
        int             d;
        logic [1:0]     rv;
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        logic [2*W-1:0] sum;
        logic           cout;
        logic           sub;
        logic           wide;
        logic [2*W:0]   exp;
        for (int i = 0; i < 40; i++) begin
            n    = int'($urandom_range(0, 1));
            a    = {$urandom, $urandom};
            b    = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            sub  = 1'($urandom_range(0, 1));
            wide = 1'($urandom_range(0, 1));
            exp  = ref_op(a, b, sub, wide);
            drive_req(n, a, b, sub, wide);
            wait_grant(n, ok);
            n_checks++;
            if (!ok) begin
                n_errors++; $display("FAIL random%0d grant: got none want req%0d", i, n);
            end
            wait_resp(lat, rv, sum, cout);
            n_checks++;
            if (lat != (wide ? 3 : 2) || rv !== 2'(1 << n)) begin
                n_errors++;
                $display("FAIL random%0d timing: got lat %0d rv %b want lat %0d rv %b",
                         i, lat, rv, wide ? 3 : 2, 2'(1 << n));
            end
            n_checks++;
            if ({cout, sum} !== exp) begin
                n_errors++;
                $display("FAIL random%0d result: got %b/%h want %b/%h (a=%h b=%h sub=%b wide=%b)",
                         i, cout, sum, exp[2*W], exp[2*W-1:0], a, b, sub, wide);
            end
            // The other requester's resp_ready must not complete this response.
            d = int'($urandom_range(0, 3));
            bus.resp_ready = 2'(1 << (1 - n));
            for (int k = 0; k < d; k++) begin
                @(posedge clk);
                @(negedge clk);
                n_checks++;
                if (bus.resp_valid !== 2'(1 << n) || bus.resp_sum !== sum) begin
                    n_errors++;
                    $display("FAIL random%0d hold: got %b/%h want %b/%h",
                             i, bus.resp_valid, bus.resp_sum, 2'(1 << n), sum);
                end
            end
            ack(n);
        end
    endtask

    task automatic test_round_robin();
        int   grants[$];
        int   cycles[$];
        int   ptr;
        clear_inputs();
        pulse_reset();
        drive_req(0, 64'd10, 64'd3, 1'b0, 1'b0);
        drive_req(1, 64'd20, 64'd4, 1'b1, 1'b0);
        bus.resp_ready = 2'b11;
        for (int c = 0; c < 40 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                n_checks++;
                if (bus.req_ready === 2'b11) begin
                    n_errors++; $display("FAIL rr onehot: got %b want one bit", bus.req_ready);
                end
                grants.push_back(bus.req_ready[1] ? 1 : 0);
                cycles.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;
        bus.resp_ready = 2'b00;
        n_checks++;
        if (grants.size() != 4) begin
            n_errors++; $display("FAIL rr grant count: got %0d want 4", grants.size());
        end
        ptr = 0;
        for (int i = 0; i < grants.size(); i++) begin
            n_checks++;
            if (grants[i] != ptr) begin
                n_errors++; $display("FAIL rr grant%0d: got req%0d want req%0d", i, grants[i], ptr);
            end
            ptr = 1 - ptr;
            if (i > 0) begin
                n_checks++;
                if (cycles[i] - cycles[i-1] != 3) begin
                    n_errors++;
                    $display("FAIL rr interval%0d: got %0d want 3", i, cycles[i] - cycles[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic           ok;
        int             lat;
        logic [1:0]     rv;
        logic [2*W-1:0] a;
        logic [2*W-1:0] b;
        logic [2*W-1:0] sum;
        logic           cout;
        logic [2*W:0]   exp;
        a   = 64'h1234_5678_9ABC_DEF0;
        b   = 64'h0F0F_0F0F_3333_3333;
        exp = ref_op(a, b, 1'b1, 1'b0);
        clear_inputs();
        drive_req(0, a, b, 1'b1, 1'b0);
        wait_grant(0, ok);
        @(negedge clk);
        n_checks++;
        if (!ok || bus.add_a !== a[W-1:0] || bus.add_b !== ~b[W-1:0] || bus.add_cin !== 1'b1) begin
            n_errors++;
            $display("FAIL stall lo operands: got %h/%h/%b want %h/%h/1",
                     bus.add_a, bus.add_b, bus.add_cin, a[W-1:0], ~b[W-1:0]);
        end
        wait_resp(lat, rv, sum, cout);
        n_checks++;
        if ({cout, sum} !== exp || rv !== 2'b01) begin
            n_errors++;
            $display("FAIL stall result: got %b/%b/%h want 01/%b/%h", rv, cout, sum,
                     exp[2*W], exp[2*W-1:0]);
        end
        bus.req_valid = 2'b11;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (bus.resp_sum !== sum || bus.resp_cout !== cout || bus.resp_valid !== 2'b01) begin
                n_errors++;
                $display("FAIL stall hold: got %b/%b/%h want 01/%b/%h",
                         bus.resp_valid, bus.resp_cout, bus.resp_sum, cout, sum);
            end
            n_checks++;
            if (bus.req_ready !== 2'b00) begin
                n_errors++; $display("FAIL stall req_ready: got %b want 00", bus.req_ready);
            end
            n_checks++;
            if (bus.add_a !== '0 || bus.add_b !== '0 || bus.add_cin !== 1'b0) begin
                n_errors++;
                $display("FAIL stall adder idle: got %h/%h/%b want 0", bus.add_a, bus.add_b, bus.add_cin);
            end
        end
        bus.req_valid = 2'b00;
        ack(0);
    endtask

    task automatic test_reset_in_hi();
        logic           ok;
        int             lat;
        logic [1:0]     rv;
        logic [2*W-1:0] a;
        logic [2*W-1:0] sum;
        logic           cout;
        a = 64'hA5A5_A5A5_FFFF_FFFF;
        clear_inputs();
        drive_req(1, a, 64'h1, 1'b0, 1'b1);
        wait_grant(1, ok);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (!ok || bus.add_a !== a[2*W-1:W] || bus.add_b !== '0 || bus.add_cin !== 1'b1) begin
            n_errors++;
            $display("FAIL hi operands: got %h/%h/%b want %h/0/1",
                     bus.add_a, bus.add_b, bus.add_cin, a[2*W-1:W]);
        end
        #1;
        drive_req(0, 64'd7, 64'd8, 1'b0, 1'b0);
        drive_req(1, 64'd100, 64'd1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00 || bus.resp_valid !== 2'b00 || bus.resp_sum !== '0 ||
            bus.resp_cout !== 1'b0 || bus.add_a !== '0 || bus.add_b !== '0 ||
            bus.add_cin !== 1'b0) begin
            n_errors++;
            $display("FAIL hi reset outputs: got rdy %b rv %b sum %h c %b add %h/%h/%b want 0",
                     bus.req_ready, bus.resp_valid, bus.resp_sum, bus.resp_cout,
                     bus.add_a, bus.add_b, bus.add_cin);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 2'b01 || bus.resp_valid !== 2'b00) begin
            n_errors++;
            $display("FAIL hi post-reset grant: got rdy %b rv %b want 01/00",
                     bus.req_ready, bus.resp_valid);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_resp(lat, rv, sum, cout);
        n_checks++;
        if (lat != 2 || rv !== 2'b01 || sum !== 64'd15 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL hi post-reset op: got lat %0d rv %b %h/%b want 2 01 f/0",
                     lat, rv, sum, cout);
        end
        ack(0);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_stall();
        test_reset_in_hi();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/add_scheduler.md
ADD_SCHEDULER -- requirements
Module: add_scheduler

Interface
REQ-001 SHALL have parameter W, default 32: width of the shared prefix adder; operand width is 2*W.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 2: bit n set means requester n presents an operation.
REQ-005 SHALL have port req_ready, output, 2: bit n set means requester n's operation is accepted this cycle.
REQ-006 SHALL have port req_a, input, 4W: operand A of requester n at bits [2W*n+2W-1 : 2W*n].
REQ-007 SHALL have port req_b, input, 4W: operand B, packed the same way as req_a.
REQ-008 SHALL have port req_sub, input, 2: bit n set means requester n computes A-B; clear means A+B.
REQ-009 SHALL have port req_wide, input, 2: bit n set means a 2W-bit operation; clear means a W-bit operation.
REQ-010 SHALL have port resp_valid, output, 2: one-hot; the result is for requester n.
REQ-011 SHALL have port resp_ready, input, 2: bit n set means requester n takes the result.
REQ-012 SHALL have port resp_sum, output, 2W: registered result.
REQ-013 SHALL have port resp_cout, output, 1: registered carry out of the top bit used (W-1 narrow, 2W-1 wide).
REQ-014 SHALL have ports add_a and add_b, output, W each: operands driven to the shared adder.
REQ-015 SHALL have port add_cin, output, 1: carry-in driven to the shared adder.
REQ-016 SHALL have port add_sum, input, W: combinational sum returned by the shared adder.
REQ-017 SHALL have port add_cout, input, 1: combinational carry out returned by the shared adder.

Function
REQ-018 SHALL implement the FSM states IDLE, LO, HI and RESP; a handshake on req_valid[n] and req_ready[n] SHALL be accepted only in IDLE.
REQ-019 SHALL assert req_ready[n] only when the state is IDLE and requester n holds the grant; at most one bit of req_ready SHALL be set.
REQ-020 SHALL grant by round-robin: if only one requester is valid, that requester wins; if both are valid, the requester favoured by the priority pointer wins; after a grant, the pointer SHALL favour the other requester.
REQ-021 SHALL, on a handshake, latch A, B, sub, wide and the grant ID, then move from IDLE to LO.
REQ-022 SHALL, in LO, drive add_a=A[W-1:0], add_b=B[W-1:0] (bitwise inverted if sub) and add_cin=sub, then register add_sum into sum[W-1:0] and add_cout as the carry.
REQ-023 SHALL move from LO to HI if wide, else to RESP with sum[2W-1:W]=0 and resp_cout=add_cout.
REQ-024 SHALL, in HI, drive the high halves (B inverted if sub) with add_cin equal to the registered LO carry, register sum[2W-1:W] and cout, then move to RESP.
REQ-025 SHALL hold add_a, add_b and add_cin at 0 in IDLE and RESP.
REQ-026 SHALL, in RESP, assert resp_valid[id] and hold resp_sum and resp_cout stable until resp_ready[id]; on that handshake it SHALL move to IDLE.
REQ-027 SHALL ignore resp_ready[n] for n not equal to id.
REQ-028 SHALL give resp_valid at T+2 for a narrow operation and T+3 for a wide one, where T is the request-handshake cycle.
REQ-029 SHALL, since IDLE is re-entered only after the response handshake, sustain at most one operation per 3 cycles (narrow) or 4 cycles (wide).
REQ-030 SHALL compute sub as two's complement (A + ~B + 1); resp_cout=1 then means no borrow.
REQ-031 SHALL wrap overflow modulo 2^(width used) with no flag other than resp_cout.

Reset
REQ-032 SHALL, while rst_n=0 (asynchronous, from any state), force: state to IDLE; req_ready, resp_valid, resp_sum, resp_cout, add_a, add_b and add_cin to 0; and the priority pointer to favour requester 0.
REQ-033 SHALL discard an in-flight operation on reset with no response; the first request after reset release SHALL be handled normally.

Verification
REQ-034 SHALL cover: narrow add on requester 0, A=0xFFFFFFFF, B=1 -> at T+2, resp_valid=01, resp_sum=0, resp_cout=1.
REQ-035 SHALL cover: wide add on requester 1, A=0x00000000_FFFFFFFF, B=1 -> at T+3, resp_valid=10, resp_sum=0x00000001_00000000, resp_cout=0.
REQ-036 SHALL cover: wide sub, A=0, B=1 -> resp_sum=0xFFFFFFFF_FFFFFFFF, resp_cout=0; and A=5, B=5 narrow -> resp_sum=0, resp_cout=1.
REQ-037 SHALL cover: both req_valid held at 1, resp_ready=11 -> grants after reset go 0,1,0,1; no requester starves.
REQ-038 SHALL cover: resp_ready held at 0 for 5 cycles in RESP -> resp_sum is stable, req_ready=00 and add_a/add_b/add_cin stay 0.
REQ-039 SHALL cover: rst_n pulsed low in HI -> all outputs 0 immediately; after release, a request from requester 1 (with both valid) loses to requester 0.
